// File: rtl/prog_loader_pkg.sv
// Shared definitions for the byte-stream boot loader: command bytes, FSM states and targets.
// LOADER_CHECKSUM_EN (optional) enables the trailing XOR byte and the CHK state.
package prog_loader_pkg;

   localparam logic [7:0] CMD_LOAD_I = 8'hA1;
   localparam logic [7:0] CMD_LOAD_D = 8'hD1;
   localparam logic [7:0] CMD_RUN    = 8'h5A;
   localparam logic [7:0] CMD_HALT   = 8'hC3;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_CNT_LO = 3'd1,
      ST_CNT_HI = 3'd2,
      ST_DATA   = 3'd3,
      ST_WRITE  = 3'd4,
      ST_RUN    = 3'd5,
      ST_ERR    = 3'd6,
      ST_CHK    = 3'd7
   } state_e;

   typedef enum logic {
      TGT_INSTR = 1'b0,
      TGT_DATA  = 1'b1
   } target_e;

   function automatic logic is_load_cmd(input logic [7:0] b);
      return (b == CMD_LOAD_I) || (b == CMD_LOAD_D);
   endfunction

endpackage

// File: rtl/prog_loader_if.sv
// Loader bus: inbound byte stream plus the BRAM write ports and run-control outputs.
// master = stream source / observer side, slave = the loader itself.
interface prog_loader_if #(
   parameter int ADDR_WIDTH = 10
);
   logic [7:0]            s_dat;
   logic                  s_valid;
   logic                  s_ready;
   logic [ADDR_WIDTH-1:0] i_w_addr;
   logic [31:0]           i_w_dat;
   logic                  i_w_enb;
   logic [ADDR_WIDTH-1:0] d_w_addr;
   logic [31:0]           d_w_dat;
   logic                  d_w_enb;
   logic                  pc_stall;
   logic                  i_r_enb;
   logic                  busy;
   logic                  err;

   modport master (
      output s_dat, s_valid,
      input  s_ready, i_w_addr, i_w_dat, i_w_enb, d_w_addr, d_w_dat, d_w_enb,
             pc_stall, i_r_enb, busy, err
   );

   modport slave (
      input  s_dat, s_valid,
      output s_ready, i_w_addr, i_w_dat, i_w_enb, d_w_addr, d_w_dat, d_w_enb,
             pc_stall, i_r_enb, busy, err
   );
endinterface

// File: rtl/prog_loader_byte_packer.sv
// 8->32 little-endian word assembler: the first byte of a word lands in [7:0].
// word_nxt/word_done are combinational so the caller can capture the full word on the 4th byte.
module byte_packer (
   input  logic        clk,
   input  logic        rst,
   input  logic        clr,
   input  logic        byte_vld,
   input  logic [7:0]  byte_in,
   output logic [31:0] word_nxt,
   output logic        word_done
);

   // Only the three most recent bytes need storing; the fourth arrives with word_done.
   logic [23:0] word_q, word_d;
   logic [1:0]  cnt_q, cnt_d;

   always_comb begin
      word_nxt  = {byte_in, word_q};
      word_done = byte_vld && (cnt_q == 2'd3);
      word_d    = word_q;
      cnt_d     = cnt_q;
      if (clr) begin
         word_d = '0;
         cnt_d  = '0;
      end else if (byte_vld) begin
         word_d = word_nxt[31:8];
         cnt_d  = cnt_q + 2'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         word_q <= '0;
         cnt_q  <= '0;
      end else begin
         word_q <= word_d;
         cnt_q  <= cnt_d;
      end
   end

endmodule

// File: rtl/prog_loader.sv
// Framed byte-stream boot loader writing 32-bit words into instruction/data BRAMs and gating run.
// Optional trailing XOR checksum per frame when LOADER_CHECKSUM_EN is defined.
module prog_loader
   import prog_loader_pkg::*;
#(
   parameter int ADDR_WIDTH = 10,
   parameter int MAX_WORDS  = 256
) (
   input  logic         clk,
   input  logic         rst,
   prog_loader_if.slave bus
);

   state_e                state_q, state_d;
   target_e               tgt_q, tgt_d;
   logic [7:0]            cnt_lo_q, cnt_lo_d;
   logic [15:0]           count_q, count_d;
   logic [15:0]           word_idx_q, word_idx_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [ADDR_WIDTH-1:0] i_w_addr_q, i_w_addr_d, d_w_addr_q, d_w_addr_d;
   logic [31:0]           i_w_dat_q, i_w_dat_d, d_w_dat_q, d_w_dat_d;
   logic                  i_w_enb_q, i_w_enb_d, d_w_enb_q, d_w_enb_d;
   logic                  pc_stall_q, pc_stall_d;
   logic                  i_r_enb_q, i_r_enb_d;
   logic                  err_q, err_d;
`ifdef LOADER_CHECKSUM_EN
   logic [7:0]            chk_q, chk_d;
`endif

   logic        s_ready, accept;
   logic        pack_vld, pack_clr, word_done;
   logic [31:0] word_nxt;
   logic [15:0] count_new;

   assign s_ready   = (state_q != ST_WRITE);
   assign accept    = bus.s_valid && s_ready;
   assign pack_vld  = accept && (state_q == ST_DATA);
   assign count_new = {bus.s_dat, cnt_lo_q};

   byte_packer u_packer (
      .clk       (clk),
      .rst       (rst),
      .clr       (pack_clr),
      .byte_vld  (pack_vld),
      .byte_in   (bus.s_dat),
      .word_nxt  (word_nxt),
      .word_done (word_done)
   );

   always_comb begin
      state_d    = state_q;
      tgt_d      = tgt_q;
      cnt_lo_d   = cnt_lo_q;
      count_d    = count_q;
      word_idx_d = word_idx_q;
      addr_d     = addr_q;
      i_w_addr_d = i_w_addr_q;
      i_w_dat_d  = i_w_dat_q;
      d_w_addr_d = d_w_addr_q;
      d_w_dat_d  = d_w_dat_q;
      i_w_enb_d  = 1'b0;
      d_w_enb_d  = 1'b0;
      pack_clr   = 1'b0;
`ifdef LOADER_CHECKSUM_EN
      chk_d      = chk_q;
`endif

      case (state_q)
         ST_IDLE: begin
            if (accept) begin
               if (is_load_cmd(bus.s_dat)) begin
                  state_d = ST_CNT_LO;
                  tgt_d   = (bus.s_dat == CMD_LOAD_D) ? TGT_DATA : TGT_INSTR;
               end else if (bus.s_dat == CMD_RUN) begin
                  state_d = ST_RUN;
               end else begin
                  state_d = ST_ERR;
               end
            end
         end
         ST_CNT_LO: begin
            if (accept) begin
               cnt_lo_d = bus.s_dat;
               state_d  = ST_CNT_HI;
            end
         end
         ST_CNT_HI: begin
            if (accept) begin
               count_d = count_new;
               if (count_new == 16'd0) begin
                  state_d = ST_IDLE;
               end else if ({16'd0, count_new} > MAX_WORDS) begin
                  state_d = ST_ERR;
               end else begin
                  state_d    = ST_DATA;
                  word_idx_d = '0;
                  addr_d     = '0;
                  pack_clr   = 1'b1;
`ifdef LOADER_CHECKSUM_EN
                  chk_d      = '0;
`endif
               end
            end
         end
         ST_DATA: begin
            if (accept) begin
`ifdef LOADER_CHECKSUM_EN
               chk_d = chk_q ^ bus.s_dat;
`endif
               // Strobe is registered here so it is high during the WRITE cycle.
               if (word_done) begin
                  state_d = ST_WRITE;
                  if (tgt_q == TGT_DATA) begin
                     d_w_enb_d  = 1'b1;
                     d_w_addr_d = addr_q;
                     d_w_dat_d  = word_nxt;
                  end else begin
                     i_w_enb_d  = 1'b1;
                     i_w_addr_d = addr_q;
                     i_w_dat_d  = word_nxt;
                  end
               end
            end
         end
         ST_WRITE: begin
            word_idx_d = word_idx_q + 16'd1;
            addr_d     = addr_q + ADDR_WIDTH'(4);
            if (word_idx_q == count_q - 16'd1) begin
`ifdef LOADER_CHECKSUM_EN
               state_d = ST_CHK;
`else
               state_d = ST_IDLE;
`endif
            end else begin
               state_d = ST_DATA;
            end
         end
`ifdef LOADER_CHECKSUM_EN
         ST_CHK: begin
            if (accept) begin
               state_d = (bus.s_dat == chk_q) ? ST_IDLE : ST_ERR;
            end
         end
`endif
         ST_RUN: begin
            if (accept && (bus.s_dat == CMD_HALT)) begin
               state_d = ST_IDLE;
            end
         end
         ST_ERR: begin
            state_d = ST_ERR;
         end
         default: begin
            state_d = ST_ERR;
         end
      endcase

      // Run-control outputs follow the state being entered, so they change on that edge.
      pc_stall_d = (state_d != ST_RUN);
      i_r_enb_d  = (state_d == ST_RUN);
      err_d      = (state_d == ST_ERR);
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q    <= ST_IDLE;
         tgt_q      <= TGT_INSTR;
         cnt_lo_q   <= '0;
         count_q    <= '0;
         word_idx_q <= '0;
         addr_q     <= '0;
         i_w_addr_q <= '0;
         i_w_dat_q  <= '0;
         i_w_enb_q  <= 1'b0;
         d_w_addr_q <= '0;
         d_w_dat_q  <= '0;
         d_w_enb_q  <= 1'b0;
         pc_stall_q <= 1'b1;
         i_r_enb_q  <= 1'b0;
         err_q      <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
         chk_q      <= '0;
`endif
      end else begin
         state_q    <= state_d;
         tgt_q      <= tgt_d;
         cnt_lo_q   <= cnt_lo_d;
         count_q    <= count_d;
         word_idx_q <= word_idx_d;
         addr_q     <= addr_d;
         i_w_addr_q <= i_w_addr_d;
         i_w_dat_q  <= i_w_dat_d;
         i_w_enb_q  <= i_w_enb_d;
         d_w_addr_q <= d_w_addr_d;
         d_w_dat_q  <= d_w_dat_d;
         d_w_enb_q  <= d_w_enb_d;
         pc_stall_q <= pc_stall_d;
         i_r_enb_q  <= i_r_enb_d;
         err_q      <= err_d;
`ifdef LOADER_CHECKSUM_EN
         chk_q      <= chk_d;
`endif
      end
   end

   assign bus.s_ready  = s_ready;
   assign bus.i_w_addr = i_w_addr_q;
   assign bus.i_w_dat  = i_w_dat_q;
   assign bus.i_w_enb  = i_w_enb_q;
   assign bus.d_w_addr = d_w_addr_q;
   assign bus.d_w_dat  = d_w_dat_q;
   assign bus.d_w_enb  = d_w_enb_q;
   assign bus.pc_stall = pc_stall_q;
   assign bus.i_r_enb  = i_r_enb_q;
   assign bus.err      = err_q;
   assign bus.busy     = (state_q == ST_CNT_LO) || (state_q == ST_CNT_HI) ||
                         (state_q == ST_DATA)   || (state_q == ST_WRITE)  ||
                         (state_q == ST_CHK);

endmodule

// File: tb/tb_prog_loader.sv
// Randomized self-checking bench for prog_loader: a frame-level model predicts every BRAM write.
// Builds with or without LOADER_CHECKSUM_EN.
module tb_prog_loader;
   import prog_loader_pkg::*;

   localparam int AW   = 10;
   localparam int MAXW = 256;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   prog_loader_if #(.ADDR_WIDTH(AW)) bus ();

   prog_loader #(.ADDR_WIDTH(AW), .MAX_WORDS(MAXW)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   typedef struct {
      bit          tgt;
      logic [31:0] addr;
      logic [31:0] dat;
      int          cyc;
   } wr_t;

   typedef enum {M_IDLE, M_RUN, M_ERR} mmode_e;

   wr_t        exp_q[$];
   wr_t        obs_q[$];
   logic [7:0] pay_q[$];
   mmode_e     mmode = M_IDLE;
   int         n_checks = 0;
   int         n_fail = 0;
   int         cyc = 0;
   int         both_cnt = 0;

   always @(posedge clk) cyc <= cyc + 1;

   // Observed write log, sampled mid-cycle.
   always @(negedge clk) begin
      wr_t o;
      if (bus.i_w_enb === 1'b1 && bus.d_w_enb === 1'b1) both_cnt <= both_cnt + 1;
      if (bus.i_w_enb === 1'b1) begin
         o.tgt = 1'b0; o.addr = 32'(bus.i_w_addr); o.dat = bus.i_w_dat; o.cyc = cyc;
         obs_q.push_back(o);
      end
      if (bus.d_w_enb === 1'b1) begin
         o.tgt = 1'b1; o.addr = 32'(bus.d_w_addr); o.dat = bus.d_w_dat; o.cyc = cyc;
         obs_q.push_back(o);
      end
   end

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   // Drive one byte (optionally after a random gap); acc is the cycle number of the accepting edge.
   task automatic send_byte(input logic [7:0] b, output int acc);
      bit got = 1'b0;
      acc = 0;
      if ($urandom_range(0, 3) == 0) begin
         repeat ($urandom_range(1, 3)) begin
            @(posedge clk); #1;
         end
      end
      bus.s_dat   = b;
      bus.s_valid = 1'b1;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (bus.s_ready === 1'b1) begin
            acc = cyc;
            got = 1'b1;
            break;
         end
      end
      if (!got) check_eq("s_ready_timeout", 32'd0, 32'd1);
      @(posedge clk); #1;
      bus.s_valid = 1'b0;
   endtask

   task automatic compare_writes(input string tag);
      int n;
      check_eq({tag, "_nwr"}, 32'(obs_q.size()), 32'(exp_q.size()));
      n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
      for (int i = 0; i < n; i++) begin
         check_eq({tag, "_tgt"},  32'(obs_q[i].tgt), 32'(exp_q[i].tgt));
         check_eq({tag, "_addr"}, obs_q[i].addr, exp_q[i].addr);
         check_eq({tag, "_dat"},  obs_q[i].dat,  exp_q[i].dat);
         check_eq({tag, "_cyc"},  32'(obs_q[i].cyc), 32'(exp_q[i].cyc));
      end
      obs_q.delete();
      exp_q.delete();
   endtask

   task automatic check_status(input string tag);
      check_eq({tag, "_busy"},     32'(bus.busy),     32'd0);
      check_eq({tag, "_err"},      32'(bus.err),      32'(mmode == M_ERR));
      check_eq({tag, "_pc_stall"}, 32'(bus.pc_stall), 32'(mmode != M_RUN));
      check_eq({tag, "_i_r_enb"},  32'(bus.i_r_enb),  32'(mmode == M_RUN));
   endtask

   task automatic fill_random(input int nbytes);
      for (int i = 0; i < nbytes; i++) pay_q.push_back(8'($urandom));
   endtask

   // Load frame from pay_q; trailing checksum only when the payload is complete.
   task automatic send_load(input logic [7:0] cmd, input int cnt, input bit bad_chk);
      int          acc;
      bit          active, valid;
      logic [7:0]  x = 8'h00;
      logic [31:0] w = 32'h0;
      wr_t         e;
      int          nexp = exp_q.size();
      active = (mmode == M_IDLE);
      valid  = active && (cnt > 0) && (cnt <= MAXW);
      send_byte(cmd, acc);
      send_byte(8'(cnt), acc);
      send_byte(8'(cnt >> 8), acc);
      if (active && cnt > MAXW) mmode = M_ERR;
      for (int j = 0; j < pay_q.size(); j++) begin
         send_byte(pay_q[j], acc);
         x = x ^ pay_q[j];
         w = {pay_q[j], w[31:8]};
         if ((j % 4) == 3 && valid) begin
            e.tgt  = (cmd == CMD_LOAD_D);
            e.addr = 32'(((j / 4) * 4) % (1 << AW));
            e.dat  = w;
            e.cyc  = acc + 1;
            exp_q.push_back(e);
         end
      end
`ifdef LOADER_CHECKSUM_EN
      if (cnt > 0 && pay_q.size() == cnt * 4) begin
         send_byte(bad_chk ? (x ^ 8'h5A) : x, acc);
         if (valid && bad_chk) mmode = M_ERR;
      end
`else
      if (bad_chk) x = x;
`endif
      repeat (2) begin
         @(posedge clk); #1;
      end
      $display("frame cmd=%02h count=%0d payload=%0d writes_expected=%0d writes_seen=%0d",
               cmd, cnt, pay_q.size(), exp_q.size() - nexp, obs_q.size());
      pay_q.delete();
   endtask

   task automatic send_single(input logic [7:0] b);
      int acc;
      send_byte(b, acc);
      if (mmode == M_IDLE) mmode = (b == CMD_RUN) ? M_RUN : M_ERR;
      else if (mmode == M_RUN && b == CMD_HALT) mmode = M_IDLE;
      $display("byte %02h -> mode %s pc_stall=%0d i_r_enb=%0d err=%0d",
               b, mmode.name(), bus.pc_stall, bus.i_r_enb, bus.err);
   endtask

   task automatic do_reset();
      rst = 1'b0;
      @(posedge clk); #1;
      rst = 1'b1;
      mmode = M_IDLE;
      $display("reset pulse");
   endtask

   initial begin
      bus.s_dat   = 8'h00;
      bus.s_valid = 1'b0;
      rst         = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_eq("rst_i_w_enb",  32'(bus.i_w_enb),  32'd0);
      check_eq("rst_d_w_enb",  32'(bus.d_w_enb),  32'd0);
      check_eq("rst_i_w_addr", 32'(bus.i_w_addr), 32'd0);
      check_eq("rst_i_w_dat",  bus.i_w_dat,       32'd0);
      check_eq("rst_d_w_addr", 32'(bus.d_w_addr), 32'd0);
      check_eq("rst_d_w_dat",  bus.d_w_dat,       32'd0);
      check_eq("rst_pc_stall", 32'(bus.pc_stall), 32'd1);
      check_eq("rst_i_r_enb",  32'(bus.i_r_enb),  32'd0);
      check_eq("rst_busy",     32'(bus.busy),     32'd0);
      check_eq("rst_err",      32'(bus.err),      32'd0);
      check_eq("rst_s_ready",  32'(bus.s_ready),  32'd1);
      @(posedge clk); #1;
      rst = 1'b1;

      // Instruction load, fixed first word.
      pay_q = '{8'h83, 8'h22, 8'h00, 8'h00};
      fill_random(16);
      send_load(CMD_LOAD_I, 5, 1'b0);
      compare_writes("t1");
      check_status("t1");
      check_eq("t1_i_addr_hold", 32'(bus.i_w_addr), 32'h10);

      // Data load, words 1..4.
      for (int k = 1; k <= 4; k++) pay_q.push_back(8'(k));
      for (int k = 1; k <= 4; k++) begin
         pay_q.delete();
         break;
      end
      for (int k = 1; k <= 4; k++) begin
         pay_q.push_back(8'(k)); pay_q.push_back(8'h00);
         pay_q.push_back(8'h00); pay_q.push_back(8'h00);
      end
      send_load(CMD_LOAD_D, 4, 1'b0);
      compare_writes("t2");
      check_status("t2");
      check_eq("t2_d_addr_hold", 32'(bus.d_w_addr), 32'hC);

      // Run, ignored bytes, halt.
      send_single(CMD_RUN);
      check_status("t3_run");
      for (int k = 0; k < 3; k++) begin
         logic [7:0] b = 8'($urandom);
         if (b == CMD_HALT) b = 8'h00;
         send_single(k == 0 ? CMD_LOAD_I : b);
         check_status("t3_ignored");
      end
      send_single(CMD_HALT);
      check_status("t3_halt");
      compare_writes("t3");

      // Bad command -> sticky error; later frame ignored; reset clears.
      send_single(8'h77);
      check_status("t4_err");
      fill_random(8);
      send_load(CMD_LOAD_I, 2, 1'b0);
      compare_writes("t4");
      check_status("t4_after");
      do_reset();
      check_status("t4_reset");

      // Oversize count, then zero count.
      send_load(CMD_LOAD_I, 257, 1'b0);
      compare_writes("t5_big");
      check_status("t5_big");
      do_reset();
      send_load(CMD_LOAD_I, 0, 1'b0);
      compare_writes("t5_zero");
      check_status("t5_zero");

      // Largest legal frame, ending at the top address.
      fill_random(MAXW * 4);
      send_load(CMD_LOAD_D, MAXW, 1'b0);
      compare_writes("max");
      check_status("max");
      check_eq("max_d_addr_hold", 32'(bus.d_w_addr), 32'((MAXW - 1) * 4));

      // Reset in the middle of word 1.
      fill_random(6);
      send_load(CMD_LOAD_I, 2, 1'b0);
      compare_writes("t6_part");
      do_reset();
      repeat (2) begin
         @(posedge clk); #1;
      end
      compare_writes("t6_rst");
      check_status("t6_rst");
      fill_random(8);
      send_load(CMD_LOAD_I, 2, 1'b0);
      compare_writes("t6_fresh");
      check_status("t6_fresh");

      // Random frames.
      for (int f = 0; f < 10; f++) begin
         int n = $urandom_range(0, 6);
         fill_random(n * 4);
         send_load(($urandom_range(0, 1) == 1) ? CMD_LOAD_D : CMD_LOAD_I, n, 1'b0);
         compare_writes("rnd");
         check_status("rnd");
      end

`ifdef LOADER_CHECKSUM_EN
      fill_random(8);
      send_load(CMD_LOAD_I, 2, 1'b1);
      compare_writes("chk_bad");
      check_status("chk_bad");
      do_reset();
`endif

      check_eq("both_enb", 32'(both_cnt), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
